ctrlpop: RTL and testbench
==========================

Name: ctrlpop

Overview:
- Extract-min controller for the 1-indexed binary min-heap held in the shared 256x8 heap memory; the companion of the push controller.
- On `start`, returns the root value on `dout` and moves the last element to the root. It then sifts that element down until heap order is restored.
- Sits beside the push controller and shares the same memory port style and the external `size` register, which it decrements via a one-cycle `sizedec` pulse.

Parameters:
- DW, 8, data width of heap entries.
- AW, 8, memory address width; max heap size 2^AW-1.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of `clk`).
- `start`  input  1  begin one pop; sampled only in IDLE.
- `mdout`  input  DW  memory read data; combinational from `maddr` in the same cycle.
- `size`  input  AW  current heap size; external register, updates on the edge after `sizedec`.
- `sizedec`  output  1  one-cycle pulse: external size <= size-1.
- `mwen`  output  1  memory write enable; writes `mdin` to `maddr` at the rising edge.
- `maddr`  output  AW  memory address.
- `mdin`  output  DW  memory write data.
- `dout`  output  DW  popped minimum; registered, holds until next successful pop.
- `err`  output  1  high together with `done` when pop was attempted on an empty heap.
- `done`  output  1  one-cycle completion pulse.

Behaviour:
- Internal registers: `idx` (AW), `tmp` (DW, element being sifted), `lc`/`rc` (DW), `rv` (right-child-valid flag), `dout` (DW).
- Reset (`reset`=0 at edge):
  - State goes to IDLE; all registers clear to 0.
  - `done`, `err`, `sizedec`, `mwen` are 0; `maddr`=0, `mdin`=0, `dout`=0.
  - Reset mid-pop aborts immediately with no further writes. Memory may hold a partially sifted heap; that is acceptable.
- States (one-hot or encoded; implementer's choice): IDLE, ROOT, LAST, LEFT, RIGHT, COMP, FIN, EMPTY.
- IDLE:
  - `maddr`=0, `mwen`=0.
  - `start`=1 and `size`==0 -> EMPTY.
  - `start`=1 and `size`>0 -> ROOT.
  - `start` is ignored in all other states.
- ROOT: `maddr`=1; `dout` <= `mdout`; `idx` <= 1; -> LAST.
- LAST: `maddr`=`size`; `tmp` <= `mdout`; `sizedec`=1; -> LEFT.
- LEFT (size now reflects the decrement):
  - Compute `l` = 2*`idx` at AW+1 bits so there is no overflow at `idx`>=128.
  - If `l` > `size` -> FIN.
  - Else `maddr`=`l`[AW-1:0]; `lc` <= `mdout`; -> RIGHT.
- RIGHT:
  - `r` = 2*`idx`+1 at AW+1 bits.
  - If `r` <= `size`: `maddr`=`r`, `rc` <= `mdout`, `rv` <= 1.
  - Else `rv` <= 0 and `maddr` is don't-care (drive `idx`).
  - -> COMP.
- COMP:
  - Selected child `c` = right iff `rv` and `rc` < `lc`; otherwise left (ties go left). `cv` is that child's value.
  - If `cv` < `tmp` (strict, unsigned): `mwen`=1, `maddr`=`idx`, `mdin`=`cv`; `idx` <= `c`; -> LEFT.
  - Else -> FIN.
- FIN:
  - `mwen`=1, `maddr`=`idx`, `mdin`=`tmp`; `done`=1; -> IDLE.
  - For size 1 before pop: size becomes 0 and FIN writes the stale `tmp` to mem[1]. This is harmless and required (no special case).
- EMPTY: `done`=1, `err`=1, no write, no `sizedec`, `dout` unchanged; -> IDLE.
- `mwen` is asserted only in COMP (when moving a child up) and in FIN. `sizedec` is asserted only in LAST.
- Latency: 3 cycles + 3 per level descended + 1. Sift stops after at most AW-1 levels.
- All comparisons are unsigned. `maddr` is a combinational function of state and registers. Outputs are glitch-tolerant because memory writes are edge-sampled.

Test Plan:
- Reset: hold `reset`=0 for 2 cycles with `start`=1 -> `done`/`mwen`/`sizedec`/`err`=0, `dout`=0, stays IDLE. Release -> a pop begins the next cycle.
- Basic pop: mem[1..5]={3,5,4,9,7}, `size`=5, pulse `start`.
  - `dout`=3, one `sizedec`, writes mem[1]=4 then mem[3]=7, `done` 7 cycles after start edge.
  - Final mem[1..4]={4,5,7,9}, `size`=4.
- No-sift and tie: mem[1..3]={1,6,6}, `size`=3 -> `dout`=1, `tmp`=6; left chosen on tie; 6<6 false -> FIN writes mem[1]=6, heap {6,6}.
- Single element / empty: `size`=1, mem[1]=42 -> `dout`=42, `size`=0, `err`=0. Then `start` again -> `done`=`err`=1 next cycle, no `mwen`, no `sizedec`, `dout` stays 42.
- Only-left-child path and deep descent: 15-entry heap of values 10..24 in order.
  - Pop returns 10; 24 sifts to a leaf. Heap property holds; a reference model compares memory after each of 15 successive pops.
  - Popped sequence is 10..24 ascending; `err` on the 16th pop.
- Mid-operation reset: assert `reset`=0 during COMP -> next cycle IDLE, no further `mwen`, `done` never pulses for that pop.

Source files
------------

// File: rtl/ctrlpop.sv
// Extract-min controller for a 1-indexed binary min-heap in a 256x8 single-port memory.
// Latency: 2 cycles (ROOT, LAST), then 3 per comparison level, 1 for the terminating LEFT probe, 1 for FIN.
// Backpressure: none; start is sampled only in IDLE and ignored while a pop is in flight.
module ctrlpop #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] mdout,
   input  logic [AW-1:0] size,
   output logic          sizedec,
   output logic          mwen,
   output logic [AW-1:0] maddr,
   output logic [DW-1:0] mdin,
   output logic [DW-1:0] dout,
   output logic          err,
   output logic          done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ROOT  = 3'd1;
   localparam logic [2:0] S_LAST  = 3'd2;
   localparam logic [2:0] S_LEFT  = 3'd3;
   localparam logic [2:0] S_RIGHT = 3'd4;
   localparam logic [2:0] S_COMP  = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;
   localparam logic [2:0] S_EMPTY = 3'd7;

   logic [2:0]    state;
   logic [2:0]    nxt;
   logic [AW-1:0] idx;
   logic [DW-1:0] tmp;
   logic [DW-1:0] lc;
   logic [DW-1:0] rc;
   logic          rv;

   // Child indices carry one extra bit so 2*idx never wraps for idx >= 2^(AW-1).
   logic [AW:0]   l;
   logic [AW:0]   r;
   logic [AW:0]   size_w;
   logic          l_ok;
   logic          r_ok;
   logic          take_right;
   logic [DW-1:0] cv;
   logic [AW-1:0] c;
   logic          move;

   assign l      = {idx, 1'b0};
   assign r      = {idx, 1'b1};
   assign size_w = {1'b0, size};
   assign l_ok   = (l <= size_w);
   assign r_ok   = (r <= size_w);

   // Ties between children go left; the child moves up only if strictly smaller than tmp.
   assign take_right = rv && (rc < lc);
   assign cv         = take_right ? rc : lc;
   assign c          = take_right ? r[AW-1:0] : l[AW-1:0];
   assign move       = (cv < tmp);

   // Next-state and memory-port decode; all outputs forced quiet while reset is held
   // so an aborted pop cannot issue a write on the reset edge.
   always_comb begin
      nxt     = state;
      maddr   = '0;
      mwen    = 1'b0;
      mdin    = '0;
      sizedec = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               nxt = (size == '0) ? S_EMPTY : S_ROOT;
            end
         end
         S_ROOT: begin
            maddr = AW'(1);
            nxt   = S_LAST;
         end
         S_LAST: begin
            maddr   = size;
            sizedec = 1'b1;
            nxt     = S_LEFT;
         end
         S_LEFT: begin
            if (!l_ok) begin
               nxt = S_FIN;
            end else begin
               maddr = l[AW-1:0];
               nxt   = S_RIGHT;
            end
         end
         S_RIGHT: begin
            maddr = r_ok ? r[AW-1:0] : idx;
            nxt   = S_COMP;
         end
         S_COMP: begin
            if (move) begin
               mwen  = 1'b1;
               maddr = idx;
               mdin  = cv;
               nxt   = S_LEFT;
            end else begin
               nxt = S_FIN;
            end
         end
         S_FIN: begin
            mwen  = 1'b1;
            maddr = idx;
            mdin  = tmp;
            done  = 1'b1;
            nxt   = S_IDLE;
         end
         S_EMPTY: begin
            done = 1'b1;
            err  = 1'b1;
            nxt  = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
      if (!reset) begin
         nxt     = S_IDLE;
         maddr   = '0;
         mwen    = 1'b0;
         mdin    = '0;
         sizedec = 1'b0;
         done    = 1'b0;
         err     = 1'b0;
      end
   end

   // State and datapath registers: capture root, last element and children as they are read.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         idx   <= '0;
         tmp   <= '0;
         lc    <= '0;
         rc    <= '0;
         rv    <= 1'b0;
         dout  <= '0;
      end else begin
         state <= nxt;
         case (state)
            S_ROOT: begin
               dout <= mdout;
               idx  <= AW'(1);
            end
            S_LAST: tmp <= mdout;
            S_LEFT: begin
               if (l_ok) lc <= mdout;
            end
            S_RIGHT: begin
               if (r_ok) begin
                  rc <= mdout;
                  rv <= 1'b1;
               end else begin
                  rv <= 1'b0;
               end
            end
            S_COMP: begin
               if (move) idx <= c;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrlpop.sv
// Bench for ctrlpop: behavioural 256x8 memory and size register around the DUT,
// directed pops queued on a scoreboard, monitor compares each done pulse.
module tb_ctrlpop;
   localparam int DW = 8;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] mdout;
   logic [AW-1:0] size;
   logic          sizedec;
   logic          mwen;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mdin;
   logic [DW-1:0] dout;
   logic          err;
   logic          done;

   ctrlpop #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .mdout(mdout), .size(size),
      .sizedec(sizedec), .mwen(mwen), .maddr(maddr), .mdin(mdin),
      .dout(dout), .err(err), .done(done)
   );

   always #5 clk = ~clk;

   // Memory and external size register; the bench's own load port has priority.
   logic [DW-1:0] mem [256];
   logic          tb_wen = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [DW-1:0] tb_dat = '0;
   logic          tb_sld = 1'b0;
   logic [AW-1:0] tb_sval = '0;

   always @(posedge clk) begin
      if (tb_wen) mem[tb_addr] <= tb_dat;
      else if (mwen) mem[maddr] <= mdin;
      if (tb_sld) size <= tb_sval;
      else if (sizedec) size <= size - 1'b1;
   end
   assign mdout = mem[maddr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int d;
      int e;
      int lat;
      int nw;
      int nsd;
      int issue;
   } exp_t;
   typedef int vec_t [16];

   exp_t sb [$];
   exp_t mon_e;
   int checks = 0;
   int passes = 0;
   int rm [256];
   int rsize = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: counts writes and size decrements per pop, checks everything on done.
   int wcnt = 0;
   int sdcnt = 0;
   always @(negedge clk) begin
      if (!reset) begin
         wcnt  = 0;
         sdcnt = 0;
      end else begin
         if (mwen) wcnt++;
         if (sizedec) sdcnt++;
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("dout", int'(dout), mon_e.d);
               chk("err", int'(err), mon_e.e);
               chk("latency", cyc - mon_e.issue + 1, mon_e.lat);
               chk("write_count", wcnt, mon_e.nw);
               chk("sizedec_count", sdcnt, mon_e.nsd);
            end
            wcnt  = 0;
            sdcnt = 0;
         end
      end
   end

   // Reference extract-min on rm[]; returns cycles-to-done, writes and size decrements.
   task automatic ref_pop(output int lat, output int nw, output int nsd);
      int t, i, lch, ch;
      if (rsize == 0) begin
         lat = 1; nw = 0; nsd = 0;
         return;
      end
      t = rm[rsize];
      rsize--;
      nsd = 1; nw = 0; lat = 2; i = 1;
      forever begin
         lch = 2 * i;
         if (lch > rsize) begin
            lat += 1;
            break;
         end
         lat += 3;
         ch = lch;
         if (lch + 1 <= rsize && rm[lch+1] < rm[lch]) ch = lch + 1;
         if (rm[ch] < t) begin
            rm[i] = rm[ch];
            nw++;
            i = ch;
         end else begin
            break;
         end
      end
      rm[i] = t;
      nw++;
      lat += 1;
   endtask

   task automatic load(input vec_t v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tb_wen  = 1'b1;
         tb_addr = AW'(i + 1);
         tb_dat  = DW'(v[i]);
         rm[i+1] = v[i];
      end
      @(negedge clk);
      tb_wen  = 1'b0;
      tb_sld  = 1'b1;
      tb_sval = AW'(n);
      rsize   = n;
      @(negedge clk);
      tb_sld = 1'b0;
   endtask

   // Push the expected response for a pop whose start edge is the next rising edge.
   task automatic expect_pop(input int exp_d, input int exp_e);
      exp_t x;
      int lat, nw, nsd;
      ref_pop(lat, nw, nsd);
      x.d = exp_d; x.e = exp_e; x.lat = lat; x.nw = nw; x.nsd = nsd;
      x.issue = cyc + 1;
      sb.push_back(x);
   endtask

   task automatic finish_pop();
      int waited = 0;
      int bad = 0;
      while (!done && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("done_seen", int'(done), 1);
      @(negedge clk);
      for (int i = 1; i <= rsize; i++) if (int'(mem[i]) != rm[i]) bad++;
      chk("mem_vs_model", bad, 0);
      chk("size", int'(size), rsize);
      bad = 0;
      for (int i = 2; i <= int'(size); i++) if (mem[i/2] > mem[i]) bad++;
      chk("heap_order", bad, 0);
   endtask

   task automatic do_pop(input int exp_d, input int exp_e);
      @(negedge clk);
      expect_pop(exp_d, exp_e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_pop();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t v15;
      int nm, nd;
      reset = 1'b0;
      start = 1'b1;

      // Reset held with start asserted while the basic heap is loaded.
      load('{3, 5, 4, 9, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 5);
      chk("rst_done", int'(done), 0);
      chk("rst_mwen", int'(mwen), 0);
      chk("rst_sizedec", int'(sizedec), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_dout", int'(dout), 0);

      // Release reset with start still high: pop begins on the next edge.
      expect_pop(3, 0);
      reset = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_pop();
      chk("basic_mem1", int'(mem[1]), 4);
      chk("basic_mem2", int'(mem[2]), 5);
      chk("basic_mem3", int'(mem[3]), 7);
      chk("basic_mem4", int'(mem[4]), 9);
      chk("basic_size", int'(size), 4);

      // Tie between children resolves left; no move since 6 < 6 is false.
      load('{1, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 3);
      do_pop(1, 0);
      chk("tie_mem1", int'(mem[1]), 6);
      chk("tie_mem2", int'(mem[2]), 6);
      chk("tie_size", int'(size), 2);

      // Single element, then pop on empty heap.
      load('{42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1);
      do_pop(42, 0);
      chk("single_size", int'(size), 0);
      do_pop(42, 1);

      // Full 15-entry heap drained in ascending order, then one empty pop.
      for (int i = 0; i < 16; i++) v15[i] = (i < 15) ? 10 + i : 0;
      load(v15, 15);
      for (int k = 0; k < 15; k++) do_pop(10 + k, 0);
      do_pop(24, 1);

      // Reset asserted while in COMP aborts the pop without its write.
      load('{3, 5, 4, 9, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 5);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("comp_write_pending", int'(mwen), 1);
      reset = 1'b0;
      #1;
      chk("abort_mwen", int'(mwen), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clk);
      chk("abort_dout", int'(dout), 0);
      reset = 1'b1;
      nm = 0;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (mwen) nm++;
         if (done) nd++;
      end
      chk("abort_no_writes", nm, 0);
      chk("abort_no_done", nd, 0);
      chk("abort_mem1", int'(mem[1]), 3);
      chk("abort_mem3", int'(mem[3]), 4);
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
